fifo_wdata_ctrl: RTL and testbench

Write-data staging buffer for the DDR3 write path, the counterpart of the read-data FIFO controller. It packs a 16-bit RGB565 pixel stream from the UART/frame-assembly front end into 128-bit DDR words and holds them in an internal show-ahead FIFO. It raises `wdata_req` once a full burst is available, and the DDR write arbiter drains words at the 128-bit side. The block is single-clock, running in the MIG `ui_clk` domain.

---
 rtl/ddr_wdata_pkg.sv | 13 +
 rtl/sync_fifo_w128.sv | 91 +++++++++
 rtl/fifo_wdata_ctrl.sv | 105 ++++++++++
 tb/tb_fifo_wdata_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_wdata_pkg.sv
// Shared widths and lane index type for the DDR write-data staging path.
package ddr_wdata_pkg;

    localparam int PIX_W        = 16;
    localparam int DDR_W        = 128;
    localparam int PIX_PER_WORD = DDR_W / PIX_W;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);

    typedef logic [LANE_W-1:0] lane_idx_t;

    localparam lane_idx_t LANE_LAST = lane_idx_t'(PIX_PER_WORD - 1);

endpackage

// File: rtl/sync_fifo_w128.sv
// Single-clock show-ahead FIFO of 128-bit words. The head word is held in a
// register so it is visible the cycle after a push into an empty FIFO, and
// resets to zero. A push into a full FIFO without a pop is rejected and
// flagged on drop.
module sync_fifo_w128
    import ddr_wdata_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DDR_W-1:0] din,
    input  logic             pop,
    output logic [DDR_W-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    logic [DDR_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DDR_W-1:0] head_q, head_d;
    logic             do_push, do_pop;
    logic [AW-1:0]    rd_next_idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = head_q;

    // Accept/reject decisions, pointer and count updates, next head word.
    always_comb begin
        do_pop      = pop && !empty;
        do_push     = push && (!full || do_pop);
        drop        = push && !do_push;
        rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Next head: the following stored word, or the incoming word when
        // it becomes the only entry.
        if (do_pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem[rd_next_idx];
            end else if (do_push) begin
                head_d = din;
            end
        end else if (do_push && empty) begin
            head_d = din;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fifo_wdata_ctrl.sv
// Write-data staging buffer: packs RGB565 pixels (lane 0 = first pixel, LSBs)
// into 128-bit DDR words and queues them in a show-ahead FIFO. wdata_req is
// raised while at least one burst of words is stored.
// Optional macro FIFO_WDATA_FLUSH_PAD_EN: a frame_sync arriving mid-word
// pushes the partial word with unfilled lanes zeroed instead of dropping it.
module fifo_wdata_ctrl
    import ddr_wdata_pkg::*;
#(
    parameter  int Brust_Length = 16,
    parameter  int FIFO_DEPTH   = 64,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             ui_clk_100MHZ,
    input  logic             Rst_n,
    input  logic             frame_sync,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_vld,
    input  logic             wdata_fifo_Rd_en,
    output logic [DDR_W-1:0] FIFO_RD_wdata,
    output logic             wdata_empty,
    output logic             wdata_full,
    output logic [CNT_W-1:0] wr_data_count,
    output logic             wdata_req,
    output logic             wdata_ovf
);

    lane_idx_t                              pix_idx_q, pix_idx_d;
    logic [PIX_PER_WORD-2:0][PIX_W-1:0]     shadow_q, shadow_d;
    logic                                   word_push;
    logic [DDR_W-1:0]                       word_data;
    logic                                   fifo_drop;
    logic                                   wdata_ovf_q, wdata_ovf_d;

`ifdef FIFO_WDATA_FLUSH_PAD_EN
    logic [DDR_W-1:0] pad_word;

    // Partial word for flush: lanes already captured, zeros elsewhere.
    for (genvar gi = 0; gi < PIX_PER_WORD - 1; gi++) begin : g_pad
        assign pad_word[gi*PIX_W +: PIX_W] =
            (lane_idx_t'(gi) < pix_idx_q) ? shadow_q[gi] : '0;
    end
    assign pad_word[DDR_W-1 -: PIX_W] = '0;
`endif

    // Packer: frame_sync restarts the word; the 8th pixel completes it.
    always_comb begin
        pix_idx_d = pix_idx_q;
        shadow_d  = shadow_q;
        word_push = 1'b0;
        word_data = {pix_data, shadow_q};

        if (frame_sync) begin
            pix_idx_d = '0;
`ifdef FIFO_WDATA_FLUSH_PAD_EN
            word_push = (pix_idx_q != '0);
            word_data = pad_word;
`endif
        end else if (pix_vld) begin
            if (pix_idx_q == LANE_LAST) begin
                word_push = 1'b1;
                pix_idx_d = '0;
            end else begin
                shadow_d[pix_idx_q] = pix_data;
                pix_idx_d           = pix_idx_q + 1'b1;
            end
        end
    end

    // Sticky overflow: set when a completed word is rejected.
    always_comb begin
        wdata_ovf_d = wdata_ovf_q | fifo_drop;
    end

    // Packer and overflow state with asynchronous active-low reset.
    always_ff @(posedge ui_clk_100MHZ or negedge Rst_n) begin
        if (!Rst_n) begin
            pix_idx_q   <= '0;
            shadow_q    <= '0;
            wdata_ovf_q <= 1'b0;
        end else begin
            pix_idx_q   <= pix_idx_d;
            shadow_q    <= shadow_d;
            wdata_ovf_q <= wdata_ovf_d;
        end
    end

    sync_fifo_w128 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ui_clk_100MHZ),
        .rst_n (Rst_n),
        .push  (word_push),
        .din   (word_data),
        .pop   (wdata_fifo_Rd_en),
        .dout  (FIFO_RD_wdata),
        .count (wr_data_count),
        .full  (wdata_full),
        .empty (wdata_empty),
        .drop  (fifo_drop)
    );

    assign wdata_req = (wr_data_count >= CNT_W'(Brust_Length));
    assign wdata_ovf = wdata_ovf_q;

endmodule

// File: tb/tb_fifo_wdata_ctrl.sv
// Directed bench for fifo_wdata_ctrl: a vector table for packing/frame_sync,
// then hand sequences for burst request, overflow, concurrent push/pop and
// asynchronous reset. Honours FIFO_WDATA_FLUSH_PAD_EN.
module tb_fifo_wdata_ctrl;

    localparam int BL    = 16;
    localparam int DEPTH = 64;
`ifdef FIFO_WDATA_FLUSH_PAD_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         frame_sync = 1'b0;
    logic         pix_vld = 1'b0;
    logic         rd_en = 1'b0;
    logic [15:0]  pix_data = '0;
    logic [127:0] head;
    logic         empty, full, req, ovf;
    logic [6:0]   count;

    int total = 0;
    int bad   = 0;

    // Scoreboard of stored words plus packer state.
    logic [127:0] mq[$];
    int           m_idx  = 0;
    logic [127:0] m_part = '0;
    logic         m_ovf  = 1'b0;

    always #5 clk = ~clk;

    fifo_wdata_ctrl #(
        .Brust_Length (BL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .ui_clk_100MHZ    (clk),
        .Rst_n            (rst_n),
        .frame_sync       (frame_sync),
        .pix_data         (pix_data),
        .pix_vld          (pix_vld),
        .wdata_fifo_Rd_en (rd_en),
        .FIFO_RD_wdata    (head),
        .wdata_empty      (empty),
        .wdata_full       (full),
        .wr_data_count    (count),
        .wdata_req        (req),
        .wdata_ovf        (ovf)
    );

    typedef struct {
        logic         fs;
        logic         vld;
        logic [15:0]  pd;
        logic         rd;
        int           cnt;
        logic         emp;
        logic         chk_head;
        logic [127:0] head;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fs, input logic vld, input logic [15:0] pd,
                                input logic rd, input int cnt, input logic emp,
                                input logic ch, input logic [127:0] h);
        vec_t v;
        v.fs = fs; v.vld = vld; v.pd = pd; v.rd = rd;
        v.cnt = cnt; v.emp = emp; v.chk_head = ch; v.head = h;
        return v;
    endfunction

    // One clock: drive inputs, sample #1 after the edge, advance the model.
    task automatic cyc(input logic fs, input logic vld, input logic [15:0] d, input logic rd);
        logic         push_v;
        logic         pop_v;
        logic [127:0] w;
        frame_sync = fs; pix_vld = vld; pix_data = d; rd_en = rd;
        @(posedge clk);
        #1;
        frame_sync = 1'b0; pix_vld = 1'b0; rd_en = 1'b0;
        push_v = 1'b0;
        w      = '0;
        if (fs) begin
`ifdef FIFO_WDATA_FLUSH_PAD_EN
            if (m_idx != 0) begin
                push_v = 1'b1;
                w      = m_part;
            end
`endif
            m_idx  = 0;
            m_part = '0;
        end else if (vld) begin
            m_part[m_idx*16 +: 16] = d;
            if (m_idx == 7) begin
                push_v = 1'b1;
                w      = m_part;
                m_idx  = 0;
                m_part = '0;
            end else begin
                m_idx++;
            end
        end
        pop_v = rd && (mq.size() > 0);
        if (pop_v) void'(mq.pop_front());
        if (push_v) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic push_word(input logic [127:0] w, input logic pop_last);
        for (int k = 0; k < 8; k++)
            cyc(1'b0, 1'b1, w[k*16 +: 16], (k == 7) ? pop_last : 1'b0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, 128'(count), 128'(mq.size()));
        chk({tag, ".empty"}, 128'(empty), 128'(mq.size() == 0));
        chk({tag, ".full"},  128'(full),  128'(mq.size() == DEPTH));
        chk({tag, ".req"},   128'(req),   128'(mq.size() >= BL));
        chk({tag, ".ovf"},   128'(ovf),   128'(m_ovf));
        if (mq.size() > 0) chk({tag, ".head"}, head, mq[0]);
    endtask

    initial begin
        logic [127:0] w;
        logic [127:0] head_before;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst.count", 128'(count), 128'd0);
        chk("rst.empty", 128'(empty), 128'd1);
        chk("rst.full",  128'(full),  128'd0);
        chk("rst.req",   128'(req),   128'd0);
        chk("rst.ovf",   128'(ovf),   128'd0);
        chk("rst.head",  head,        128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Vector table: packing order, pop, frame_sync mid-word, clean restart.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 16'(i), 0, (i == 8) ? 1 : 0, (i != 8), (i == 8),
                              128'h0008_0007_0006_0005_0004_0003_0002_0001));
        vecs.push_back(mk(0, 0, 16'h0, 1, 0, 1, 0, '0));
        for (int i = 1; i <= 3; i++)
            vecs.push_back(mk(0, 1, 16'(i), 0, 0, 1, 0, '0));
        vecs.push_back(mk(1, 1, 16'hDEAD, 0, int'(FLUSH), !FLUSH, FLUSH,
                          128'h0000_0000_0000_0000_0000_0003_0002_0001));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 16'(16 + i), 0, int'(FLUSH) + ((i == 8) ? 1 : 0),
                              !(FLUSH || i == 8), (i == 8),
                              FLUSH ? 128'h0000_0000_0000_0000_0000_0003_0002_0001
                                    : 128'h0018_0017_0016_0015_0014_0013_0012_0011));
        vecs.push_back(mk(0, 0, 16'h0, 1, int'(FLUSH), !FLUSH, FLUSH,
                          128'h0018_0017_0016_0015_0014_0013_0012_0011));
        vecs.push_back(mk(0, 0, 16'h0, 1, 0, 1, 0, '0));

        foreach (vecs[i]) begin
            cyc(vecs[i].fs, vecs[i].vld, vecs[i].pd, vecs[i].rd);
            chk($sformatf("vec%0d.count", i), 128'(count), 128'(vecs[i].cnt));
            chk($sformatf("vec%0d.empty", i), 128'(empty), 128'(vecs[i].emp));
            if (vecs[i].chk_head) chk($sformatf("vec%0d.head", i), head, vecs[i].head);
            $display("vec %0d: fs=%0b vld=%0b pd=%h rd=%0b -> count=%0d empty=%0b",
                     i, vecs[i].fs, vecs[i].vld, vecs[i].pd, vecs[i].rd, count, empty);
        end
        // Pop on empty just happened; a further pop must also change nothing.
        cyc(0, 0, 16'h0, 1);
        chk("popempty.count", 128'(count), 128'd0);
        chk("popempty.empty", 128'(empty), 128'd1);

        // 128 pixels: wdata_req rises exactly when the count reaches 16.
        for (int i = 0; i < 128; i++) begin
            cyc(0, 1, 16'(16'h0100 + i), 0);
            if (i % 8 == 7) begin
                chk($sformatf("burst%0d.count", i), 128'(count), 128'((i + 1) / 8));
                chk($sformatf("burst%0d.req", i),   128'(req),   128'(((i + 1) / 8) >= 16));
                $display("burst pixel %0d: count=%0d req=%0b", i, count, req);
            end
        end
        cyc(0, 0, 16'h0, 1);
        chk("burstpop.count", 128'(count), 128'd15);
        chk("burstpop.req",   128'(req),   128'd0);
        check_model("burstpop");

        // Fill to 64, then overflow without pop, then push with pop.
        for (int n = 0; n < 49; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            push_word(w, 1'b0);
        end
        chk("fill.count", 128'(count), 128'd64);
        chk("fill.full",  128'(full),  128'd1);
        chk("fill.ovf",   128'(ovf),   128'd0);
        head_before = mq[0];
        push_word(128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, 1'b0);
        chk("ovf.flag",  128'(ovf),   128'd1);
        chk("ovf.count", 128'(count), 128'd64);
        chk("ovf.head",  head,        head_before);
        $display("overflow push: count=%0d ovf=%0b", count, ovf);
        push_word(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b1);
        chk("fullpop.count", 128'(count), 128'd64);
        check_model("fullpop");
        for (int n = 0; n < 64; n++) begin
            cyc(0, 0, 16'h0, 1);
            check_model($sformatf("drain%0d", n));
        end
        chk("drain.last_empty", 128'(empty), 128'd1);
        cyc(0, 0, 16'h0, 1);
        chk("drainpop.count", 128'(count), 128'd0);

        // Concurrent push and pop at count 5.
        for (int n = 0; n < 5; n++) push_word({4{$urandom}}, 1'b0);
        chk("conc.pre", 128'(count), 128'd5);
        push_word(128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004, 1'b1);
        chk("conc.count", 128'(count), 128'd5);
        check_model("conc");

        // Asynchronous reset mid-packing with 10 words stored.
        for (int n = 0; n < 5; n++) push_word({4{$urandom}}, 1'b0);
        chk("prerst.count", 128'(count), 128'd10);
        for (int k = 0; k < 3; k++) cyc(0, 1, 16'(16'h0F00 + k), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.count", 128'(count), 128'd0);
        chk("arst.empty", 128'(empty), 128'd1);
        chk("arst.full",  128'(full),  128'd0);
        chk("arst.req",   128'(req),   128'd0);
        chk("arst.ovf",   128'(ovf),   128'd0);
        chk("arst.head",  head,        128'd0);
        $display("async reset: count=%0d empty=%0b ovf=%0b", count, empty, ovf);
        mq.delete();
        m_idx = 0; m_part = '0; m_ovf = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) cyc(0, 1, 16'(16'h20 + i), 0);
        chk("postrst.count", 128'(count), 128'd1);
        chk("postrst.head",  head, 128'h0028_0027_0026_0025_0024_0023_0022_0021);
        check_model("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
